// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned divider, one quotient bit per cycle by restoring division.
// Result is {remainder, quotient}; a zero divisor yields all zeros without iterating.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic        signed_q;
  logic        sign1_q;
  logic        sign2_q;

  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    dividend_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // Bit 32 of the 33-bit difference flags a negative trial subtraction.
    diff         = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    quot_fix     = (signed_q && (sign1_q ^ sign2_q)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem_fix      = (signed_q && sign1_q) ? (~work_q[64:33] + 32'd1) : work_q[64:33];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      ready_o   <= 1'b0;
      result_o  <= 64'd0;
    end else begin
      unique case (state_q)
        StFree: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= StByZero;
            end else begin
              state_q   <= StOn;
              cnt_q     <= 6'd0;
              work_q    <= {32'd0, dividend_abs, 1'b0};
              divisor_q <= divisor_abs;
              signed_q  <= signed_div_i;
              sign1_q   <= opdata1_i[31];
              sign2_q   <= opdata2_i[31];
            end
          end
        end
        StByZero: begin
          work_q   <= 65'd0;
          state_q  <= StEnd;
          ready_o  <= 1'b1;
          result_o <= 64'd0;
        end
        StOn: begin
          if (annul_i) begin
            state_q  <= StFree;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end else if (!cnt_q[5]) begin
            if (diff[32]) begin
              work_q <= {work_q[63:0], 1'b0};
            end else begin
              work_q <= {diff[31:0], work_q[31:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            state_q  <= StEnd;
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quot_fix};
          end
        end
        StEnd: begin
          if (!start_i) begin
            state_q  <= StFree;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: table of operand/result vectors plus annul and reset sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full transaction: start, scramble operands after the load edge, check latency,
  // result, END hold (with a stray annul), and return to idle.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string nm);
    int lat;
    lat = (b == 32'd0) ? 1 : 33;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sg;
    repeat (lat - 1) @(negedge clk);
    check({nm, " ready early"}, {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    check({nm, " ready"}, {63'd0, ready_o}, 64'd1);
    check({nm, " result"}, result_o, exp);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check({nm, " hold ready"}, {63'd0, ready_o}, 64'd1);
    check({nm, " hold result"}, result_o, exp);
    start_i = 1'b0;
    @(negedge clk);
    check({nm, " idle ready"}, {63'd0, ready_o}, 64'd0);
    check({nm, " idle result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen_ready;

    vecs[0]  = '{1'b0, 32'd7,          32'd2,          64'h00000001_00000003};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{1'b0, 32'h12345678,   32'd0,          64'h00000000_00000000};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF};
    vecs[5]  = '{1'b0, 32'd100,        32'd3,          64'h00000001_00000021};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003};
    vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC};
    vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
    vecs[10] = '{1'b1, 32'd0,          32'd5,          64'h00000000_00000000};
    vecs[11] = '{1'b1, 32'hFFFFFF00,   32'd0,          64'h00000000_00000000};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("free idle ready", {63'd0, ready_o}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Annul at T+10 of 100/3, with start still high so annul must also win in FREE.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul ready", {63'd0, ready_o}, 64'd0);
    repeat (2) @(negedge clk);
    start_i    = 1'b0;
    annul_i    = 1'b0;
    seen_ready = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) seen_ready++;
    end
    check("annul never ready", 64'(seen_ready), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after annul 9/3");

    // Reset at T+20 with start held, then restart on release.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midon rst ready", {63'd0, ready_o}, 64'd0);
    check("midon rst result", result_o, 64'd0);
    rst = 1'b0;
    repeat (33) @(negedge clk);
    check("restart ready early", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    check("restart ready", {63'd0, ready_o}, 64'd1);
    check("restart result", result_o, 64'h00000001_00000021);

    // Reset while in END clears the outputs.
    rst = 1'b1;
    @(negedge clk);
    check("end rst ready", {63'd0, ready_o}, 64'd0);
    check("end rst result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("final idle ready", {63'd0, ready_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have no parameters; widths are fixed: operands 32 bits, result 64 bits, counter 6 bits.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous, active-high reset, sampled on the `clk` rising edge.
REQ-004 SHALL have port `signed_div_i`, input, 1 bit: 1 = two's-complement division, 0 = unsigned.
REQ-005 SHALL have port `opdata1_i`, input, 32 bits: dividend.
REQ-006 SHALL have port `opdata2_i`, input, 32 bits: divisor.
REQ-007 SHALL have port `start_i`, input, 1 bit: request from the execute stage; held high until the result is consumed.
REQ-008 SHALL have port `annul_i`, input, 1 bit: cancel the division in progress (pipeline flush).
REQ-009 SHALL have port `result_o`, output, 64 bits: {remainder[63:32], quotient[31:0]}; upper half goes to HI, lower half to LO.
REQ-010 SHALL have port `ready_o`, output, 1 bit: 1 = `result_o` valid.

Function
REQ-011 SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 SHALL register both outputs; neither output is combinationally derived from inputs.
REQ-013 FREE, `start_i`=1, `annul_i`=0, `opdata2_i`=0: SHALL go to BYZERO.
REQ-014 FREE, `start_i`=1, `annul_i`=0, `opdata2_i`≠0: SHALL go to ON and clear the counter to 0.
REQ-015 Entry to ON SHALL load a 65-bit working register with {32'b0, |dividend|, 1'b0}.
REQ-016 Entry to ON SHALL latch |divisor|; magnitudes are taken only when `signed_div_i`=1 and the operand bit 31 = 1.
REQ-017 FREE with `start_i`=0 or `annul_i`=1: SHALL remain in FREE with `ready_o`=0 and `result_o`=0.
REQ-018 BYZERO: SHALL clear the working register to 0 and go to END unconditionally on the next edge.
REQ-019 ON, `annul_i`=0, counter<32, each cycle: compute diff = work[63:32] − divisor.
REQ-020 ON step, diff negative: work <= {work[63:0], 1'b0}.
REQ-021 ON step, diff non-negative: work <= {diff[31:0], work[31:0], 1'b1}.
REQ-022 ON step: counter SHALL increment by 1.
REQ-023 ON, counter=32: SHALL apply sign correction and go to END.
REQ-024 Sign correction, quotient: work[31:0] is negated iff `signed_div_i`=1 and the latched operand sign bits differ.
REQ-025 Sign correction, remainder: work[64:33] is negated iff `signed_div_i`=1 and the latched dividend bit 31 = 1.
REQ-026 ON, `annul_i`=1: SHALL go to FREE on that edge, discard partial results, and hold `ready_o`=0.
REQ-027 END: SHALL drive `ready_o`=1 and `result_o` = {remainder, quotient}.
REQ-028 END: SHALL remain in END while `start_i`=1.
REQ-029 END, `start_i`=0: SHALL go to FREE with `ready_o`=0 and `result_o`=0.
REQ-030 Latency, non-zero divisor: with `start_i` first sampled high at edge T, `ready_o`=1 from edge T+33 (1 load + 32 iterations).
REQ-031 Latency, zero divisor: `ready_o`=1 from edge T+1; `result_o` = 64'h0.
REQ-032 Operands SHALL be latched at edge T; changes on `opdata1_i`, `opdata2_i` or `signed_div_i` after T SHALL NOT affect the result.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, with no exception signalled.
REQ-034 `annul_i` in FREE, BYZERO or END SHALL have no effect.
REQ-035 If `start_i` and `annul_i` are both high in FREE, annul SHALL win.

Reset
REQ-036 `rst`=1 at a rising edge SHALL force state=FREE, counter=0, working register=0, `ready_o`=0 and `result_o`=64'h0, regardless of state, including mid-ON.
REQ-037 After `rst` falls, a `start_i` still held high SHALL begin a fresh division at the next edge.

Verification
REQ-038 Unsigned 7/2, start held: -> `ready_o`=1 at T+33, `result_o`=64'h00000001_00000003; after `start_i` drops, `ready_o`=0 next edge.
REQ-039 Signed −7/2 (0xFFFFFFF9, 0x00000002): -> `result_o`=64'hFFFFFFFF_FFFFFFFD.
REQ-040 Divisor 0, dividend 0x12345678: -> `ready_o`=1 at T+1, `result_o`=64'h0.
REQ-041 Signed 0x80000000 / 0xFFFFFFFF: -> `result_o`=64'h00000000_80000000; unsigned 0xFFFFFFFF/0x10: -> 64'h0000000F_0FFFFFFF.
REQ-042 `annul_i`=1 at T+10 during 100/3: -> FREE at T+10, `ready_o` never rises; a new 9/3 started later returns 64'h00000000_00000003 at its T'+33.
REQ-043 `rst`=1 at T+20 during a division: -> all outputs 0 next edge; `start_i` held -> restart, correct result 33 edges after release.
